// File: rtl/instruction_fetch.sv
// Fetch stage: PC, instruction register, halt/fault control.
// Optional valid-fetch counter built when FETCH_COUNT_EN is defined.
module instruction_fetch #(
   parameter int unsigned MEM_DEPTH   = 31,
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter logic [4:0]  HALT_OPCODE = 5'b00110,
   parameter logic [31:0] NOP_WORD    = 32'h20000000
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] instruction_address,
   input  logic [31:0] instruction_data_input,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        resume,
   output logic [31:0] fetched_instruction,
   output logic [31:0] fetched_pc,
   output logic        fetch_valid,
   output logic        halted,
   output logic        address_fault,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_HALT  = 2'd1;
   localparam logic [1:0] S_FAULT = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] fpc_q, fpc_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;
   logic        pc_oor;
   logic        fetch_ld;
   logic        is_halt;

   assign pc_oor  = (pc_q >= MEM_DEPTH);
   assign is_halt = (instruction_data_input[31:27] == HALT_OPCODE);

   // A real capture happens only in RUN with no flush, no fault, no stall.
   assign fetch_ld = (state_q == S_RUN) && !branch_taken
                     && !pc_oor && !stall;

   // Next-state logic; branch flush beats fault check beats stall.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      fpc_d    = fpc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      case (state_q)
         S_RUN: begin
            if (branch_taken) begin
               pc_d    = branch_target;
               ir_d    = NOP_WORD;
               valid_d = 1'b0;
            end else if (pc_oor) begin
               state_d  = S_FAULT;
               fault_d  = 1'b1;
               halted_d = 1'b1;
               valid_d  = 1'b0;
            end else if (fetch_ld) begin
               ir_d    = instruction_data_input;
               fpc_d   = pc_q;
               valid_d = 1'b1;
               if (is_halt) begin
                  state_d  = S_HALT;
                  halted_d = 1'b1;
               end else begin
                  pc_d = pc_q + 32'd1;
               end
            end
         end
         S_HALT: begin
            valid_d = 1'b0;
            if (resume) begin
               pc_d     = pc_q + 32'd1;
               halted_d = 1'b0;
               state_d  = S_RUN;
            end
         end
         S_FAULT: begin
            valid_d  = 1'b0;
            halted_d = 1'b1;
            fault_d  = 1'b1;
         end
         default: begin
            state_d = S_FAULT;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_RUN;
         pc_q     <= RESET_PC;
         ir_q     <= NOP_WORD;
         fpc_q    <= 32'd0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         fpc_q    <= fpc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end

`ifdef FETCH_COUNT_EN
   logic [31:0] cnt_q;

   // Count every edge that loads a valid instruction.
   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= 32'd0;
      else if (fetch_ld)
         cnt_q <= cnt_q + 32'd1;
   end

   assign fetch_count = cnt_q;
`else
   assign fetch_count = 32'd0;
`endif

   assign instruction_address = pc_q;
   assign fetched_instruction = ir_q;
   assign fetched_pc          = fpc_q;
   assign fetch_valid         = valid_q;
   assign halted              = halted_q;
   assign address_fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table plus random run
// against a behavioural model.
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h20000000;
   localparam logic [31:0] HW  = 32'h30000000;

   logic        clock;
   logic        reset;
   logic [31:0] instruction_address;
   logic [31:0] instruction_data_input;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        resume;
   logic [31:0] fetched_instruction;
   logic [31:0] fetched_pc;
   logic        fetch_valid;
   logic        halted;
   logic        address_fault;
   logic [31:0] fetch_count;

   logic [31:0] mem [32];

   int total = 0;
   int bad   = 0;

   instruction_fetch dut (
      .clock                  (clock),
      .reset                  (reset),
      .instruction_address    (instruction_address),
      .instruction_data_input (instruction_data_input),
      .stall                  (stall),
      .branch_taken           (branch_taken),
      .branch_target          (branch_target),
      .resume                 (resume),
      .fetched_instruction    (fetched_instruction),
      .fetched_pc             (fetched_pc),
      .fetch_valid            (fetch_valid),
      .halted                 (halted),
      .address_fault          (address_fault),
      .fetch_count            (fetch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign instruction_data_input =
      (instruction_address < 32) ? mem[instruction_address[4:0]] : 32'h0;

   // ---------------- behavioural model ----------------
   int          m_mode;   // 0 running, 1 halted, 2 faulted
   logic [31:0] m_pc, m_ir, m_fpc, m_cnt;
   logic        m_valid, m_halted, m_fault;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a < 32) ? mem[a[4:0]] : 32'h0;
   endfunction

   task automatic model_step(input logic rst, input logic st,
                             input logic br, input logic [31:0] tgt,
                             input logic res);
      logic [31:0] w;
      if (rst) begin
         m_mode = 0; m_pc = 0; m_ir = NOP; m_fpc = 0;
         m_valid = 0; m_halted = 0; m_fault = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
         if (br) begin
            m_pc = tgt; m_ir = NOP; m_valid = 0;
         end else if (m_pc >= 31) begin
            m_mode = 2; m_fault = 1; m_halted = 1; m_valid = 0;
         end else if (!st) begin
            w = word_at(m_pc);
            m_ir = w; m_fpc = m_pc; m_valid = 1;
            m_cnt = m_cnt + 1;
            if (w[31:27] == 5'b00110) begin
               m_mode = 1; m_halted = 1;
            end else begin
               m_pc = m_pc + 1;
            end
         end
      end else if (m_mode == 1) begin
         m_valid = 0;
         if (res) begin
            m_pc = m_pc + 1; m_halted = 0; m_mode = 0;
         end
      end else begin
         m_valid = 0;
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef FETCH_COUNT_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic rst, input logic st,
                        input logic br, input logic [31:0] tgt,
                        input logic res);
      reset = rst; stall = st; branch_taken = br;
      branch_target = tgt; resume = res;
      model_step(rst, st, br, tgt, res);
      @(posedge clock);
      #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic        rst, st, br, res;
      logic [31:0] tgt;
      logic [31:0] addr, fpc, ir;
      logic        v, h, f;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] W(input int i);
      return 32'h58000000 | 32'(i);
   endfunction

   task automatic row(input logic rst, input logic st, input logic br,
                      input logic [31:0] tgt, input logic res,
                      input logic [31:0] addr, input logic [31:0] fpc,
                      input logic [31:0] ir, input logic v,
                      input logic h, input logic f);
      vec_t r;
      r.rst = rst; r.st = st; r.br = br; r.tgt = tgt; r.res = res;
      r.addr = addr; r.fpc = fpc; r.ir = ir;
      r.v = v; r.h = h; r.f = f;
      tbl.push_back(r);
   endtask

   initial begin
      reset = 1; stall = 0; branch_taken = 0;
      branch_target = 0; resume = 0;
      for (int i = 0; i < 32; i++) mem[i] = W(i);
      mem[21] = HW;

      //  rst st br tgt res   addr fpc ir      v h f
      row(1, 0, 0, 0, 0,     0,  0,  NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     1,  0,  W(0),   1, 0, 0);
      row(0, 0, 0, 0, 0,     2,  1,  W(1),   1, 0, 0);
      row(0, 0, 0, 0, 0,     3,  2,  W(2),   1, 0, 0);
      row(0, 0, 0, 0, 0,     4,  3,  W(3),   1, 0, 0);
      row(0, 0, 0, 0, 0,     5,  4,  W(4),   1, 0, 0);
      row(0, 1, 0, 0, 0,     5,  4,  W(4),   1, 0, 0);
      row(0, 1, 0, 0, 0,     5,  4,  W(4),   1, 0, 0);
      row(0, 1, 0, 0, 0,     5,  4,  W(4),   1, 0, 0);
      row(0, 0, 0, 0, 0,     6,  5,  W(5),   1, 0, 0);
      row(0, 0, 0, 0, 0,     7,  6,  W(6),   1, 0, 0);
      row(0, 0, 0, 0, 0,     8,  7,  W(7),   1, 0, 0);
      row(0, 0, 0, 0, 0,     9,  8,  W(8),   1, 0, 0);
      row(0, 1, 1, 13, 0,    13, 8,  NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     14, 13, W(13),  1, 0, 0);
      row(0, 0, 1, 20, 0,    20, 13, NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     21, 20, W(20),  1, 0, 0);
      row(0, 0, 0, 0, 0,     21, 21, HW,     1, 1, 0);
      row(0, 0, 0, 0, 0,     21, 21, HW,     0, 1, 0);
      row(0, 0, 1, 3, 0,     21, 21, HW,     0, 1, 0);
      row(0, 1, 0, 0, 0,     21, 21, HW,     0, 1, 0);
      row(0, 0, 0, 0, 0,     21, 21, HW,     0, 1, 0);
      row(0, 0, 0, 0, 0,     21, 21, HW,     0, 1, 0);
      row(0, 0, 0, 0, 1,     22, 21, HW,     0, 0, 0);
      row(0, 0, 0, 0, 0,     23, 22, W(22),  1, 0, 0);
      row(0, 0, 1, 40, 0,    40, 22, NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     40, 22, NOP,    0, 1, 1);
      row(0, 0, 0, 0, 1,     40, 22, NOP,    0, 1, 1);
      row(0, 0, 1, 3, 0,     40, 22, NOP,    0, 1, 1);
      row(1, 0, 0, 0, 0,     0,  0,  NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     1,  0,  W(0),   1, 0, 0);
      row(0, 0, 1, 21, 0,    21, 0,  NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     21, 21, HW,     1, 1, 0);
      row(0, 0, 0, 0, 0,     21, 21, HW,     0, 1, 0);
      row(1, 0, 0, 0, 1,     0,  0,  NOP,    0, 0, 0);
      row(0, 0, 0, 0, 0,     1,  0,  W(0),   1, 0, 0);

      foreach (tbl[k]) begin
         apply(tbl[k].rst, tbl[k].st, tbl[k].br, tbl[k].tgt, tbl[k].res);
         chk($sformatf("row%0d addr", k), instruction_address, tbl[k].addr);
         chk($sformatf("row%0d fpc", k), fetched_pc, tbl[k].fpc);
         chk($sformatf("row%0d ir", k), fetched_instruction, tbl[k].ir);
         chk($sformatf("row%0d valid", k), 32'(fetch_valid), 32'(tbl[k].v));
         chk($sformatf("row%0d halted", k), 32'(halted), 32'(tbl[k].h));
         chk($sformatf("row%0d fault", k), 32'(address_fault), 32'(tbl[k].f));
         chk($sformatf("row%0d count", k), fetch_count, exp_count());
         if (k == 4) begin
`ifdef FETCH_COUNT_EN
            chk("count after 4 fetches", fetch_count, 32'd4);
`else
            chk("count tied off", fetch_count, 32'd0);
`endif
         end
      end

      // ---------------- random run against model ----------------
      for (int i = 0; i < 32; i++) begin
         logic [31:0] w;
         w = $urandom;
         if ($urandom_range(7) == 0) w[31:27] = 5'b00110;
         else if (w[31:27] == 5'b00110) w[31:27] = 5'b00111;
         mem[i] = w;
      end
      apply(1, 0, 0, 0, 0);
      for (int c = 0; c < 3000; c++) begin
         logic rr, ss, bb, re;
         logic [31:0] tt;
         rr = ($urandom_range(99) < 2);
         ss = ($urandom_range(99) < 25);
         bb = ($urandom_range(99) < 10);
         re = ($urandom_range(99) < 30);
         tt = 32'($urandom_range(33));
         apply(rr, ss, bb, tt, re);
         chk($sformatf("rnd%0d addr", c), instruction_address, m_pc);
         chk($sformatf("rnd%0d ir", c), fetched_instruction, m_ir);
         chk($sformatf("rnd%0d fpc", c), fetched_pc, m_fpc);
         chk($sformatf("rnd%0d flags", c),
             {29'd0, fetch_valid, halted, address_fault},
             {29'd0, m_valid, m_halted, m_fault});
         chk($sformatf("rnd%0d count", c), fetch_count, exp_count());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
